// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// FSM encoding, wait-counter sizing and address range helper.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W   = 4;
  localparam int LAT_MAX = 15;

  // True when any byte-address bit above the array span is set.
  function automatic logic out_of_range(
    input logic [31:0] addr,
    input int          aw
  );
    logic [31:0] hi;
    hi = addr >> (aw + 2);
    return hi != 32'd0;
  endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Single-port synchronous RAM, byte-enable write, registered read.
// Contents are never reset; only the read register is.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage.
// One request in flight; stall held until a one-cycle response.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(LATENCY);

  state_t                state;
  state_t                state_nx;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nx;

  logic                  wr_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;

  logic                  accept;
  logic                  access;
  logic                  req_err;
  logic [ADDR_WIDTH-1:0] req_idx;

  logic                  acc_wr;
  logic                  acc_err;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [31:0]           acc_wdata;
  logic [3:0]            acc_be;

  logic                  ram_en;
  logic [31:0]           ram_q;

  assign accept  = (state == IDLE) && req_valid;
  assign req_err = out_of_range(req_addr, ADDR_WIDTH);
  assign req_idx = req_addr[ADDR_WIDTH+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    access   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          cnt_nx = LAT;
          if (LAT == '0) begin
            state_nx = RESP;
            access   = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt - 1'b1;
        if (cnt <= 1) begin
          state_nx = RESP;
          access   = 1'b1;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (accept) begin
      wr_q    <= req_write;
      err_q   <= req_err;
      idx_q   <= req_idx;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  // Zero latency enters RESP straight from IDLE, before capture lands.
  always_comb begin
    if (state == IDLE) begin
      acc_wr    = req_write;
      acc_err   = req_err;
      acc_idx   = req_idx;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_wr    = wr_q;
      acc_err   = err_q;
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
  end

  assign ram_en = access && !acc_err;

  dmem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .en   (ram_en),
    .we   (acc_wr),
    .be   (acc_be),
    .addr (acc_idx),
    .wdata(acc_wdata),
    .rdata(ram_q)
  );

  assign stall      = accept || (state == WAIT);
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid && err_q;

  always_comb begin
    resp_rdata = '0;
    if (resp_valid && !wr_q && !err_q) begin
      resp_rdata = ram_q;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder at latencies 2, 0, 5, 15.
// Expected responses are queued at issue and checked on resp_valid.
module tb_dmem_responder;

  localparam int N = 4;

  function automatic int lat_of(input int g);
    case (g)
      0:       return 2;
      1:       return 0;
      2:       return 5;
      default: return 15;
    endcase
  endfunction

  typedef struct {
    int          k;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [N];
  logic        req_write  [N];
  logic [31:0] req_addr   [N];
  logic [31:0] req_wdata  [N];
  logic [3:0]  req_be     [N];
  logic        stall      [N];
  logic        resp_valid [N];
  logic [31:0] resp_rdata [N];
  logic        resp_err   [N];

  exp_t        sb[$];
  logic [31:0] model[int];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    dmem_responder #(
      .ADDR_WIDTH(10),
      .LATENCY   (lat_of(g))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_write (req_write[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_be    (req_be[g]),
      .stall     (stall[g]),
      .resp_valid(resp_valid[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g])
    );
  end

  function automatic int key(input int k, input logic [31:0] a);
    return k * 4096 + int'(a[11:2]);
  endfunction

  function automatic void push_expect(
    input int k, input logic wr, input logic [31:0] a,
    input logic [31:0] wd, input logic [3:0] be
  );
    exp_t        e;
    logic        oor;
    logic [31:0] w;
    oor     = (a[31:12] != 20'd0);
    e.k     = k;
    e.err   = oor;
    e.rdata = 32'd0;
    if (wr) begin
      if (!oor) begin
        w = model.exists(key(k, a)) ? model[key(k, a)] : 32'd0;
        for (int i = 0; i < 4; i++)
          if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
        model[key(k, a)] = w;
      end
    end else if (!oor) begin
      e.rdata = model[key(k, a)];
    end
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (resp_valid[k] === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_resp dut=%0d rdata=%h", k,
                   resp_rdata[k]);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.k != k || resp_rdata[k] !== e.rdata ||
              resp_err[k] !== e.err) begin
            bad++;
            $display("FAIL resp dut=%0d got rdata=%h err=%b want dut=%0d rdata=%h err=%b",
                     k, resp_rdata[k], resp_err[k], e.k, e.rdata, e.err);
          end
        end
      end
    end
  end

  task automatic drive(
    input  int k, input logic wr, input logic [31:0] a,
    input  logic [31:0] wd, input logic [3:0] be,
    output int cyc, output int stalls,
    output logic [31:0] rd, output logic er
  );
    push_expect(k, wr, a, wd, be);
    @(posedge clk); #1;
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k]  = a;
    req_wdata[k] = wd;
    req_be[k]    = be;
    cyc    = -1;
    stalls = 0;
    rd     = 'x;
    er     = 1'bx;
    for (int c = 0; c < 40 && cyc < 0; c++) begin
      @(negedge clk);
      if (stall[k] === 1'b1) stalls++;
      if (resp_valid[k] === 1'b1) begin
        cyc = c;
        rd  = resp_rdata[k];
        er  = resp_err[k];
      end
    end
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    if (cyc < 0 && sb.size() > 0) void'(sb.pop_back());
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      total++;
      if ({stall[k], resp_valid[k], resp_err[k], resp_rdata[k]} !== 35'd0) begin
        bad++;
        $display("FAIL reset_outputs dut=%0d got=%b/%b/%b/%h want=0",
                 k, stall[k], resp_valid[k], resp_err[k], resp_rdata[k]);
      end
    end
    req_valid[1] = 1'b1;
    #1;
    total++;
    if (stall[1] !== 1'b1) begin
      bad++;
      $display("FAIL reset_stall_follows got=%b want=1", stall[1]);
    end
    req_valid[1] = 1'b0;
    #1;
    total++;
    if (stall[1] !== 1'b0) begin
      bad++;
      $display("FAIL reset_stall_drop got=%b want=0", stall[1]);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    int cyc, st; logic [31:0] rd; logic er;
    drive(0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, cyc, st, rd, er);
    total++;
    if (cyc != 3 || st != 3) begin
      bad++;
      $display("FAIL store_timing got cyc=%0d stall=%0d want 3/3", cyc, st);
    end
    drive(0, 1'b0, 32'h40, 32'h0, 4'h0, cyc, st, rd, er);
    total++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || cyc != 3) begin
      bad++;
      $display("FAIL load_back got rd=%h er=%b cyc=%0d want deadbeef/0/3",
               rd, er, cyc);
    end
  endtask

  task automatic test_byte_enable();
    int cyc, st; logic [31:0] rd; logic er;
    drive(0, 1'b1, 32'h40, 32'h11223344, 4'b0101, cyc, st, rd, er);
    drive(0, 1'b0, 32'h40, 32'h0, 4'h0, cyc, st, rd, er);
    total++;
    if (rd !== 32'hDE22BE44) begin
      bad++;
      $display("FAIL be_merge got=%h want=de22be44", rd);
    end
    drive(0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'h0, cyc, st, rd, er);
    total++;
    if (cyc != 3 || er !== 1'b0) begin
      bad++;
      $display("FAIL be_zero_resp got cyc=%0d er=%b want 3/0", cyc, er);
    end
    drive(0, 1'b0, 32'h40, 32'h0, 4'h0, cyc, st, rd, er);
    total++;
    if (rd !== 32'hDE22BE44) begin
      bad++;
      $display("FAIL be_zero_keep got=%h want=de22be44", rd);
    end
  endtask

  task automatic test_zero_latency();
    int cyc, st; logic [31:0] rd; logic er;
    logic [31:0] addrs [3];
    int idx;
    addrs[0] = 32'h100;
    addrs[1] = 32'h104;
    addrs[2] = 32'h108;
    for (int i = 0; i < 3; i++)
      drive(1, 1'b1, addrs[i], 32'hA000_0000 + i, 4'hF, cyc, st, rd, er);
    total++;
    if (cyc != 1 || st != 1) begin
      bad++;
      $display("FAIL zero_lat_timing got cyc=%0d stall=%0d want 1/1", cyc, st);
    end
    push_expect(1, 1'b0, addrs[0], 32'h0, 4'h0);
    @(posedge clk); #1;
    req_valid[1] = 1'b1;
    req_write[1] = 1'b0;
    req_addr[1]  = addrs[0];
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (stall[1] !== (c % 2 == 0) || resp_valid[1] !== (c % 2 == 1)) begin
        bad++;
        $display("FAIL b2b_cycle c=%0d got stall=%b rv=%b want stall=%b rv=%b",
                 c, stall[1], resp_valid[1], c % 2 == 0, c % 2 == 1);
      end
      if (c % 2 == 1 && idx < 2) begin
        idx++;
        req_addr[1] = addrs[idx];
        push_expect(1, 1'b0, addrs[idx], 32'h0, 4'h0);
      end
    end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
  endtask

  task automatic test_out_of_range();
    int cyc, st; logic [31:0] rd; logic er;
    drive(0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, cyc, st, rd, er);
    drive(0, 1'b1, 32'h0000_1000, 32'hFFFFFFFF, 4'hF, cyc, st, rd, er);
    total++;
    if (er !== 1'b1 || cyc != 3) begin
      bad++;
      $display("FAIL oor_store got er=%b cyc=%0d want 1/3", er, cyc);
    end
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0, cyc, st, rd, er);
    total++;
    if (rd !== 32'h0BADF00D) begin
      bad++;
      $display("FAIL oor_no_alias got=%h want=0badf00d", rd);
    end
    drive(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, cyc, st, rd, er);
    total++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      bad++;
      $display("FAIL oor_load got rd=%h er=%b want 0/1", rd, er);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, st, seen; logic [31:0] rd; logic er;
    drive(2, 1'b1, 32'h80, 32'hCAFEF00D, 4'hF, cyc, st, rd, er);
    total++;
    if (cyc != 6 || st != 6) begin
      bad++;
      $display("FAIL lat5_timing got cyc=%0d stall=%0d want 6/6", cyc, st);
    end
    @(posedge clk); #1;
    req_valid[2] = 1'b1;
    req_write[2] = 1'b1;
    req_addr[2]  = 32'h80;
    req_wdata[2] = 32'h12345678;
    req_be[2]    = 4'hF;
    repeat (4) @(negedge clk);
    total++;
    if (stall[2] !== 1'b1) begin
      bad++;
      $display("FAIL mid_stall got=%b want=1", stall[2]);
    end
    rst = 1'b1;
    req_valid[2] = 1'b0;
    #1;
    total++;
    if (stall[2] !== 1'b0 || resp_valid[2] !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_idle got stall=%b rv=%b want 0/0",
               stall[2], resp_valid[2]);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid[2] === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL mid_no_resp got=%0d want=0", seen);
    end
    drive(2, 1'b0, 32'h80, 32'h0, 4'h0, cyc, st, rd, er);
    total++;
    if (rd !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL mid_no_commit got=%h want=cafef00d", rd);
    end
  endtask

  task automatic test_max_latency();
    int cyc, st; logic [31:0] rd; logic er;
    drive(3, 1'b1, 32'h200, 32'h5A5A5A5A, 4'hF, cyc, st, rd, er);
    drive(3, 1'b0, 32'h200, 32'h0, 4'h0, cyc, st, rd, er);
    total++;
    if (cyc != 16 || st != 16 || rd !== 32'h5A5A5A5A) begin
      bad++;
      $display("FAIL max_lat got cyc=%0d stall=%0d rd=%h want 16/16/5a5a5a5a",
               cyc, st, rd);
    end
    @(negedge clk);
    total++;
    if (resp_valid[3] !== 1'b0) begin
      bad++;
      $display("FAIL max_lat_single_pulse got=%b want=0", resp_valid[3]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      req_valid[k] = 1'b0;
      req_write[k] = 1'b0;
      req_addr[k]  = 32'h0;
      req_wdata[k] = 32'h0;
      req_be[k]    = 4'h0;
    end
    test_reset();
    test_store_load();
    test_byte_enable();
    test_zero_latency();
    test_out_of_range();
    test_reset_mid();
    test_max_latency();
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drained got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder that sits on the far side of the CPU's MEM stage. It accepts one load or store request at a time and holds `stall` high while the access is in flight. It then returns read data with a one-cycle response pulse. A configurable wait-state count emulates slow memory and exercises the pipeline's `mem_stall` path.

## Interface

Parameters:
- `ADDR_WIDTH`, 10: word-address bits. Depth is 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, 2: wait-state cycles between accept and response. Legal range 0..15.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req_valid` in 1: request present. The requester holds all `req_*` stable until the `resp_valid` cycle.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address. Bits [1:0] are ignored; the word index is `req_addr[ADDR_WIDTH+1:2]`.
- `req_wdata` in 32: store data.
- `req_be` in 4: store byte enables, bit i → byte [8i+7:8i]. Ignored for loads.
- `stall` out 1: high while a request is pending and unanswered. It feeds the pipeline's `mem_stall`.
- `resp_valid` out 1: one-cycle pulse when the access completes.
- `resp_rdata` out 32: load data. It is valid only while `resp_valid` is high and is 0 for stores.
- `resp_err` out 1: out-of-range address, qualified by `resp_valid`.

## Operation

- FSM states are IDLE, WAIT and RESP.
- **IDLE:** if `req_valid` is high, capture `req_write`, the address, `req_wdata` and `req_be`, and set the out-of-range flag (`req_addr[31:ADDR_WIDTH+2]` ≠ 0).
  - Load the wait counter with `LATENCY`.
  - Go to WAIT, or directly to RESP when `LATENCY` = 0.
- **WAIT:** decrement the counter each cycle. When the counter reaches 0, go to RESP.
- **Memory access:** happens on the edge entering RESP.
  - Store: write the enabled bytes only.
  - Load: register the full word into `resp_rdata`.
  - Out-of-range: no write, `resp_rdata` = 0, `resp_err` = 1.
- **RESP:** `resp_valid` = 1 for exactly one cycle, then unconditionally return to IDLE. The request is never re-accepted in RESP.
- `stall` = (IDLE & `req_valid`) | WAIT. It is combinational and low in RESP, so the pipeline advances on that edge.
- A store with `req_be` = 0 completes normally and leaves memory unchanged.
- `req_valid` dropping mid-request is a protocol violation. The transaction still completes from the captured values.

## Timing

- **Reset values:** state IDLE, `resp_valid` 0, `resp_rdata` 0, `resp_err` 0, counter 0.
  - `stall` follows `req_valid` combinationally in IDLE.
  - Memory contents are not reset.
- **Latency:** a request presented in IDLE in cycle 0 produces `resp_valid` in cycle `LATENCY`+1. `stall` is high in cycles 0..`LATENCY`.
- **Throughput:** one request per `LATENCY`+2 cycles. The next request is accepted no earlier than the IDLE cycle after RESP.
- **Read-after-write:** a load to a word stored by the previous transaction returns the new data, because the store committed on its RESP-entry edge.
- **Reset mid-operation:** the pending transaction is abandoned. A store in WAIT is not committed, no response is issued, and the state returns to IDLE immediately.

## Structure

- A shared package holds:
  - the FSM state encoding (IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2);
  - the wait-counter width (4);
  - the `LATENCY` legal maximum (15).
- Sub-module `dmem_array`: a single-port synchronous RAM with byte-enable write and registered read, 2^ADDR_WIDTH × 32.
- The top level holds the FSM, counter, capture registers and range check.

## Test plan

- **Store then load:** `LATENCY`=2. Store 0xDEADBEEF to 0x40 with `req_be`=4'hF; `resp_valid` arrives in cycle 3 with `stall` high in cycles 0–2. Then load 0x40 → `resp_rdata`=0xDEADBEEF, `resp_err`=0.
- **Byte-enable store:** word 0x40 = 0xDEADBEEF. Store 0x11223344 with `req_be`=4'b0101, then load → 0xDE22BE44. A store with `req_be`=0 leaves the word unchanged.
- **Zero latency:** `LATENCY`=0. Back-to-back loads with `req_valid` held high get `resp_valid` every 2nd cycle and `stall` high only in the accept cycles.
- **Out-of-range:** `ADDR_WIDTH`=10. Store to 0x0000_1000 → `resp_err`=1 with no memory change. A load from the same address → `resp_rdata`=0, `resp_err`=1.
- **Reset mid-operation:** `LATENCY`=5. Assert `rst` in cycle 3 of a store to 0x80 → no `resp_valid`, state IDLE. A subsequent load of 0x80 returns the prior contents.
- **Maximum latency:** `LATENCY`=15. `stall` is high for exactly 16 cycles and `resp_valid` pulses once in cycle 16.
